// File: rtl/neuron_mac.sv
// Fixed-point neuron: MAC over N_INPUTS samples, then bias, ReLU and saturation to DATA_W.
// Latency: result valid 2 edges after the edge accepting the last beat (one FINAL cycle).
// Backpressure: input stalls (in_ready=0) in FINAL/OUTPUT; result held until out_ready.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   w_we, w_addr, w_data       weight write port (ignored for w_addr >= N_INPUTS)
//   bias                       signed bias, sampled during FINAL
//   in_valid/in_ready/in_data  activation sample stream
//   out_valid/out_ready/out_data  8-bit result stream (0..2**(DATA_W-1)-1)
//   busy                       high while a vector is in flight
module neuron_mac #(
  parameter int N_INPUTS  = 4,
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_we,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy
);

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_FINAL  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam int PROD_W = 2 * DATA_W;

  // One extra bit so N_INPUTS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]        N_LIM     = (ADDR_W+1)'(N_INPUTS);
  localparam logic [ADDR_W-1:0]      LAST_IDX  = ADDR_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] SAT_OUT = DATA_W'((2 ** (DATA_W - 1)) - 1);

  logic [1:0]               state;
  logic [ADDR_W-1:0]        count;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] w [N_INPUTS];

  logic                     beat;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  r;
  logic signed [DATA_W-1:0] result;

  assign in_ready = (state == ST_ACCUM);
  assign beat     = in_valid && in_ready;
  assign busy     = (state != ST_ACCUM) || (count != '0);

  always_comb begin
    // Operands are widened before the multiply so the full signed product is kept.
    prod     = PROD_W'(in_data) * PROD_W'(w[count]);
    prod_ext = ACC_W'(prod);
    // Arithmetic shift floors toward minus infinity, matching the Q-format rescale.
    shifted  = acc >>> FRAC_BITS;
    bias_ext = ACC_W'(bias);
    r        = shifted + bias_ext;
    if (r[ACC_W-1]) begin
      result = '0;
    end else if (r > SAT_MAX) begin
      result = SAT_OUT;
    end else begin
      result = r[DATA_W-1:0];
    end
  end

  // Weight store. A write racing the MAC read of the same index lands on the
  // same edge, so the MAC sees the old value and the new one from the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w[i] <= '0;
      end
    end else if (w_we && ({1'b0, w_addr} < N_LIM)) begin
      w[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_ACCUM;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (beat) begin
            acc <= acc + prod_ext;
            if (count == LAST_IDX) begin
              count <= '0;
              state <= ST_FINAL;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_FINAL: begin
          out_data  <= result;
          out_valid <= 1'b1;
          acc       <= '0;
          state     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: table of vectors plus hand-written corner sequences.
// Inputs driven and outputs sampled on the falling edge.
// Checks value, latency, single-cycle pulse, backpressure, gaps, weight hazard, reset.
module tb_neuron_mac;

  logic              clk = 1'b0;
  logic              reset;
  logic              w_we;
  logic [1:0]        w_addr;
  logic signed [7:0] w_data;
  logic signed [7:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_mac #(
    .N_INPUTS(4), .ADDR_W(2), .DATA_W(8), .FRAC_BITS(4), .ACC_W(20)
  ) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  typedef struct {
    int w0, w1, w2, w3;
    int x0, x1, x2, x3;
    int b;
    int exp;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic load_w(input int w0, input int w1, input int w2, input int w3);
    int ws[4];
    ws = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_we   = 1'b1;
      w_addr = 2'(i);
      w_data = 8'(ws[i]);
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Streams one vector; gap inserts an idle cycle before each later beat,
  // haz writes w[1]=32 on the edge that accepts beat 1.
  task automatic send_vec(input int x0, input int x1, input int x2, input int x3,
                          input int b, input bit gap, input bit haz);
    int xs[4];
    int g;
    xs   = '{x0, x1, x2, x3};
    bias = 8'(b);
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
        chk("gap_busy", int'(busy), 1);
      end
      @(negedge clk);
      w_we     = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'(xs[i]);
      if (haz && i == 1) begin
        w_we   = 1'b1;
        w_addr = 2'd1;
        w_data = 8'sd32;
      end
      g = 0;
      while (!in_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (g >= 20) chk("in_ready_timeout", 0, 1);
    end
  endtask

  // Returns the number of falling edges after the last beat until out_valid (0 = timeout).
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      w_we     = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full vector with out_ready high: value, latency, one-cycle pulse, ready again.
  task automatic run_vec(input string nm, input int x0, input int x1, input int x2,
                         input int x3, input int b, input bit gap, input bit haz,
                         input int exp);
    int lat;
    send_vec(x0, x1, x2, x3, b, gap, haz);
    wait_out(lat);
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_data"}, int'(out_data), exp);
    @(negedge clk);
    chk({nm, "_pulse_once"}, int'(out_valid), 0);
    chk({nm, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;

    // Hand-computed: r = floor(sum(w*x)/16) + b, then clamp to 0..127.
    tbl[0] = '{16, 16, 16, 16,   16,  16,  16,  16,  8,  72};  // 1024 -> 64+8
    tbl[1] = '{16, 16, 16, 16,  -16, -16, -16, -16,  8,   0};  // -64+8 = -56
    tbl[2] = '{16, 16, 16, 16,   16,  32,  48,  64,  0, 127};  // 160 saturates
    tbl[3] = '{ 1,  2,  3,  4,   16,  16,  16,  16,  0,  10};  // 160/16 per-lane weights
    tbl[4] = '{16,  0,  0,-16,   32,  99, -99,  16,  3,  19};  // 256/16 + 3
    tbl[5] = '{16, 16, 16, 16,   64,  63,   0,   0,  0, 127};  // exactly 127
    tbl[6] = '{16, 16, 16, 16,   64,  64,   0,   0,  0, 127};  // 128 -> 127
    tbl[7] = '{ 1,  1,  1,  1,   -1,   0,   0,   0,  2,   1};  // floor(-1/16)=-1, +2
    tbl[8] = '{16, 16, 16, 16,    1,   0,   0,   0, -2,   0};  // 1-2 = -1 -> 0

    reset     = 1'b0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_held_out_valid", int'(out_valid), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);

    for (int i = 0; i < 9; i++) begin
      load_w(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3);
      run_vec($sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].x3,
              tbl[i].b, 1'b0, 1'b0, tbl[i].exp);
    end

    // Backpressure: result held for 5 stalled cycles, then handshake.
    load_w(16, 16, 16, 16);
    out_ready = 1'b0;
    send_vec(16, 16, 16, 16, 8, 1'b0, 1'b0);
    wait_out(lat);
    chk("bp_latency", lat, 2);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 72);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    chk("bp_still_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", int'(out_valid), 0);
    chk("bp_done_in_ready", int'(in_ready), 1);

    // Gapped input.
    run_vec("gap", 16, 16, 16, 16, 8, 1'b1, 1'b0, 72);

    // Weight hazard: old w[1] used for this vector, new w[1]=32 for the next.
    run_vec("haz_first", 16, 16, 16, 16, 8, 1'b0, 1'b1, 72);
    run_vec("haz_second", 16, 16, 16, 16, 8, 1'b0, 1'b0, 88);

    // Reset mid-vector, asserted and released between clock edges.
    load_w(16, 16, 16, 16);
    bias = 8'sd8;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'sd16;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    #4 reset = 1'b1;
    // Weights cleared: only the bias survives.
    run_vec("post_rst_zero_w", 16, 16, 16, 16, 8, 1'b0, 1'b0, 8);
    load_w(16, 16, 16, 16);
    run_vec("post_rst_reload", 16, 16, 16, 16, 8, 1'b0, 1'b0, 72);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
Single fixed-point neuron stage that feeds the accelerator's 8-bit output path. It consumes one activation vector of N_INPUTS signed samples over a valid/ready stream and multiply-accumulates each sample against a locally stored weight. It then adds a bias, applies ReLU and saturation, and presents one 8-bit result on a valid/ready output. Weights are loaded through a simple write port before or between vectors.

Parameters:
N_INPUTS, 4, samples per vector (weights stored)
ADDR_W, 2, weight address width; N_INPUTS <= 2**ADDR_W
DATA_W, 8, signed width of samples, weights, bias, result (Q(DATA_W-FRAC_BITS).FRAC_BITS)
FRAC_BITS, 4, fractional bits of the fixed-point format
ACC_W, 20, signed accumulator width; must be >= 2*DATA_W + ADDR_W + 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
w_we  input  1  weight write strobe
w_addr  input  ADDR_W  weight index to write
w_data  input  DATA_W  signed weight value
bias  input  DATA_W  signed bias, sampled in FINAL
in_valid  input  1  input sample valid
in_ready  output  1  block accepts a sample
in_data  input  DATA_W  signed input sample
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_W  signed result, 0..2**(DATA_W-1)-1
busy  output  1  high whenever state != ACCUM or count != 0

Behaviour:
- Reset (reset low, asynchronous): state=ACCUM, count=0, acc=0, out_valid=0, out_data=0, all weights=0. in_ready=1 after release, busy=0.
- FSM states: ACCUM, FINAL, OUTPUT.
- ACCUM: in_ready=1. A beat is accepted on an edge where in_valid&&in_ready. On each accepted beat: acc <= acc + sext(in_data*w[count]) (full signed 2*DATA_W product), and count++. The edge accepting beat N_INPUTS-1 sets count=0 and moves to FINAL. No beat means no change.
- FINAL (exactly 1 cycle, in_ready=0):
  - r = (acc >>> FRAC_BITS) + sext(bias). The shift is arithmetic (floor).
  - ReLU: r<0 gives 0. Saturate: r>2**(DATA_W-1)-1 gives 2**(DATA_W-1)-1.
  - out_data <= result, out_valid <= 1, acc <= 0, next state OUTPUT.
- OUTPUT: in_ready=0. out_data and out_valid are held stable until out_valid&&out_ready. On that edge out_valid <= 0 and the state returns to ACCUM. The next vector's first beat is accepted no earlier than the following edge.
- Latency: out_valid is high in the cycle after FINAL, i.e. visible 2 edges after the edge accepting the last beat (the last-beat edge counts as the first).
- Throughput: at most one vector per N_INPUTS+2 cycles with out_ready tied high.
- Weight writes: accepted in any state on w_we. If w_addr >= N_INPUTS, the write is ignored. A write to w[count] on the same edge that beat count is accepted: the MAC uses the old weight, and the new value is visible from the next edge.
- in_data is ignored when in_ready=0. in_valid may drop mid-vector; accumulation pauses, no timeout.
- Reset asserted mid-vector or during OUTPUT: partial sum and pending result are discarded, and weights are cleared. No out_valid is issued for the aborted vector.
- The accumulator never overflows, given the ACC_W constraint; no overflow logic is required.

Test Plan:
1. Nominal: write w[0..3]=16 (1.0); bias=8 (0.5); stream in_data 16,16,16,16 back-to-back with out_ready=1. Required: acc=1024, out_data=72 (4.5). out_valid is high for exactly one cycle, 2 edges after the 4th beat.
2. ReLU: same weights; in_data -16 x4, bias=8. Required: r=-56, out_data=0, out_valid pulses once.
3. Saturation: weights 16; in_data 16,32,48,64, bias=0. Required: r=160, out_data=127.
4. Backpressure: as test 1 but out_ready=0 for 5 cycles after out_valid rises. Required:
   - out_data stays 72 and out_valid stays 1 for all 5 cycles; in_ready stays 0.
   - Handshake completes on the first out_ready=1 edge, and in_ready=1 on the next cycle.
5. Gapped input plus weight hazard:
   - in_valid toggles 1,0,1,0,... over a vector of 16,16,16,16 with weights 16. Required: out_data=72, regardless of the gaps.
   - Separately, with all weights 16, write w[1]=32 on the same edge beat 1 is accepted. Required: that vector gives 72; the next identical vector gives 88.
6. Reset mid-vector: accept 2 beats, pulse reset low for 1 cycle asynchronously (between edges). Required:
   - out_valid=0 and busy=0 immediately.
   - Weights read as 0, so after reloading weights=16 a fresh vector of 16 x4 with bias=8 gives 72, with no stale partial sum.
